// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
// Package     : score_pkg
// Description : Shared types and constants for the Doodle Fall score stage:
//               FSM state encodings, score/display widths and a saturating
//               add helper.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    // Width of the score and high-score registers (holds 0..9999)
    localparam int SCORE_W = 14;
    // Width of the binary display word handed to ssdCtrl
    localparam int DOUT_W  = 32;
    // Width of the per-cycle sum, one bit wider than the score so the
    // addition cannot wrap before it is clamped
    localparam int SUM_W   = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_e;

    // Add points to a score and clamp the result at the given ceiling
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] base,
        input logic [SUM_W-1:0]   add,
        input logic [SCORE_W-1:0] ceiling
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + add;
        if (sum > {1'b0, ceiling}) begin
            return ceiling;
        end
        return sum[SCORE_W-1:0];
    endfunction

endpackage : score_pkg
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_gen
// Description : Free-running clock divider. Asserts tick_o for one cycle
//               every TICK_DIV cycles (the cycle in which the counter sits
//               at TICK_DIV-1), then the counter wraps to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_LAST);

    // Divider counter: count up, wrap to zero on the tick cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Doodle Fall game-score stage. Accumulates LAND/CLIMB points
//               while playing, saturating at SCORE_MAX, tracks the session
//               high score and drives the binary display word plus a
//               score/high-score select flag. In GAME_OVER the display
//               alternates between score and high score every ALT_MS ms.
//               Optional build macro SCORE_COMBO_EN: a LAND within COMBO_MS
//               ms of the previous LAND of the same game scores double.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter int SCORE_MAX = 9999,
    parameter int LAND_PTS  = 1,
    parameter int CLIMB_PTS = 10,
    parameter int TICK_DIV  = 100000,
    parameter int ALT_MS    = 500,
    parameter int COMBO_MS  = 750
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              LAND,
    input  logic              CLIMB,
    input  logic              DEAD,
    output logic [DOUT_W-1:0] DOUT,
    output logic              SHOW_HI,
    output logic              HI_NEW,
    output logic [1:0]        STATE
);

    localparam int                 ALT_W    = (ALT_MS > 1) ? $clog2(ALT_MS) : 1;
    localparam logic [ALT_W-1:0]   ALT_LAST = ALT_W'(ALT_MS - 1);
    localparam logic [SCORE_W-1:0] CEILING  = SCORE_W'(SCORE_MAX);

    // Parameter sanity: the ceiling must fit the score register and the
    // combo window must be at least one millisecond
    if (SCORE_MAX >= (2 ** SCORE_W)) begin : g_chk_score_max
        $error("score_keeper: SCORE_MAX does not fit in SCORE_W bits");
    end
    if (COMBO_MS < 1) begin : g_chk_combo_ms
        $error("score_keeper: COMBO_MS must be at least 1");
    end

    state_e             state_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [SCORE_W-1:0] hi_q;
    logic [DOUT_W-1:0]  dout_q;
    logic               sel_hi_q;   // internal select; the outputs follow it one cycle later
    logic               show_hi_q;
    logic               hi_new_q;
    logic [ALT_W-1:0]   alt_cnt_q;

    logic               tick;
    logic               play_entry;
    logic [SUM_W-1:0]   land_pts;
    logic [SUM_W-1:0]   points;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick_gen (
        .clk_i  (CLK),
        .rst_i  (RST),
        .tick_o (tick)
    );

    // A new game starts on START from any state other than PLAY
    assign play_entry = START && (state_q != PLAY);

`ifdef SCORE_COMBO_EN
    localparam int               CMB_W       = $clog2(COMBO_MS + 1);
    localparam logic [CMB_W-1:0] CMB_EXPIRED = CMB_W'(COMBO_MS);

    logic [CMB_W-1:0] combo_q;
    logic             combo_hit;

    assign combo_hit = (combo_q != CMB_EXPIRED);
    assign land_pts  = combo_hit ? SUM_W'(2 * LAND_PTS) : SUM_W'(LAND_PTS);

    // Combo timer: ms since the last LAND, parked at "expired" at game start
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            combo_q <= CMB_EXPIRED;
        end else if (play_entry) begin
            combo_q <= CMB_EXPIRED;
        end else if ((state_q == PLAY) && LAND) begin
            combo_q <= '0;
        end else if (tick && combo_hit) begin
            combo_q <= combo_q + 1'b1;
        end
    end
`else
    assign land_pts = SUM_W'(LAND_PTS);
`endif

    // Points earned this cycle and the clamped next score
    always_comb begin
        points = '0;
        if (LAND) begin
            points = points + land_pts;
        end
        if (CLIMB) begin
            points = points + SUM_W'(CLIMB_PTS);
        end
        score_d = sat_add(score_q, points, CEILING);
    end

    // Game FSM with score, high score, display alternation and the
    // registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            score_q   <= '0;
            hi_q      <= '0;
            dout_q    <= '0;
            sel_hi_q  <= 1'b1;
            show_hi_q <= 1'b1;
            hi_new_q  <= 1'b0;
            alt_cnt_q <= '0;
        end else begin
            // Display word and flag lag the select by one cycle together,
            // so a score change reaches DOUT the cycle after it is stored
            dout_q    <= {{(DOUT_W - SCORE_W){1'b0}}, (sel_hi_q ? hi_q : score_q)};
            show_hi_q <= sel_hi_q;

            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q   <= PLAY;
                        score_q   <= '0;
                        hi_new_q  <= 1'b0;
                        alt_cnt_q <= '0;
                        sel_hi_q  <= 1'b0;
                    end
                end

                PLAY: begin
                    // Same-cycle points count before DEAD ends the game;
                    // DEAD takes priority over a simultaneous START
                    score_q <= score_d;
                    if (DEAD) begin
                        state_q  <= OVER;
                        sel_hi_q <= 1'b0;
                        if (score_d > hi_q) begin
                            hi_q     <= score_d;
                            hi_new_q <= 1'b1;
                        end
                    end
                end

                OVER: begin
                    if (START) begin
                        state_q   <= PLAY;
                        score_q   <= '0;
                        hi_new_q  <= 1'b0;
                        alt_cnt_q <= '0;
                        sel_hi_q  <= 1'b0;
                    end else if (tick) begin
                        if (alt_cnt_q == ALT_LAST) begin
                            alt_cnt_q <= '0;
                            sel_hi_q  <= ~sel_hi_q;
                        end else begin
                            alt_cnt_q <= alt_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    sel_hi_q <= 1'b1;
                end
            endcase
        end
    end

    assign DOUT    = dout_q;
    assign SHOW_HI = show_hi_q;
    assign HI_NEW  = hi_new_q;
    assign STATE   = state_q;

endmodule : score_keeper
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Directed, self-checking bench for score_keeper. Uses a small
//               reference model of score/high score/state; expected display
//               values are queued when a pulse is driven and popped when the
//               DUT output is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int TB_MAX   = 9999;
    localparam int TB_LP    = 1;
    localparam int TB_CP    = 10;
    localparam int TB_TICK  = 10;
    localparam int TB_ALT   = 3;
    localparam int TB_COMBO = 750;

    logic        CLK   = 1'b0;
    logic        RST   = 1'b0;
    logic        START = 1'b0;
    logic        LAND  = 1'b0;
    logic        CLIMB = 1'b0;
    logic        DEAD  = 1'b0;
    logic [31:0] DOUT;
    logic        SHOW_HI;
    logic        HI_NEW;
    logic [1:0]  STATE;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    // Reference model
    int m_score   = 0;
    int m_hi      = 0;
    int m_hi_new  = 0;
    int m_state   = 0;
    int m_land_ok = 0;
    longint m_land_cyc = 0;
    longint cyc = 0;

    score_keeper #(
        .SCORE_MAX (TB_MAX),
        .LAND_PTS  (TB_LP),
        .CLIMB_PTS (TB_CP),
        .TICK_DIV  (TB_TICK),
        .ALT_MS    (TB_ALT),
        .COMBO_MS  (TB_COMBO)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .LAND    (LAND),
        .CLIMB   (CLIMB),
        .DEAD    (DEAD),
        .DOUT    (DOUT),
        .SHOW_HI (SHOW_HI),
        .HI_NEW  (HI_NEW),
        .STATE   (STATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock cycle with the given inputs
    task automatic model_cycle(input bit l, input bit c, input bit d, input bit s);
        int add;
        if (m_state == 1) begin
            add = 0;
            if (l) begin
                add = TB_LP;
`ifdef SCORE_COMBO_EN
                if (m_land_ok != 0 && (cyc - m_land_cyc) < longint'((TB_COMBO - 1) * TB_TICK))
                    add = 2 * TB_LP;
                m_land_ok  = 1;
                m_land_cyc = cyc;
`endif
            end
            if (c) add = add + TB_CP;
            m_score = (m_score + add > TB_MAX) ? TB_MAX : m_score + add;
            if (d) begin
                m_state = 2;
                if (m_score > m_hi) begin
                    m_hi     = m_score;
                    m_hi_new = 1;
                end
            end
        end else if (s) begin
            m_state   = 1;
            m_score   = 0;
            m_hi_new  = 0;
            m_land_ok = 0;
        end
    endtask

    // One-cycle pulse; result checked when it is due on DOUT (2 cycles later)
    task automatic pulse(input string tag, input bit l, input bit c, input bit d, input bit s);
        @(negedge CLK);
        LAND = l; CLIMB = c; DEAD = d; START = s;
        model_cycle(l, c, d, s);
        exp_q.push_back(m_score);
        @(negedge CLK);
        LAND = 0; CLIMB = 0; DEAD = 0; START = 0;
        @(negedge CLK);
        check({tag, "_dout"}, DOUT, exp_q.pop_front());
        check({tag, "_state"}, {30'd0, STATE}, m_state);
        check({tag, "_hi_new"}, {31'd0, HI_NEW}, m_hi_new);
        check({tag, "_show_hi"}, {31'd0, SHOW_HI}, (m_state == 0) ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, DOUT, 0);
        check({tag, "_show_hi"}, {31'd0, SHOW_HI}, 1);
        check({tag, "_hi_new"}, {31'd0, HI_NEW}, 0);
        check({tag, "_state"}, {30'd0, STATE}, 0);
    endtask

    task automatic model_reset();
        m_score = 0; m_hi = 0; m_hi_new = 0; m_state = 0; m_land_ok = 0;
    endtask

    // Watchdog: never hang
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k;
        int  n;
        bit  seen;
        bit  held;
        int  base;

        // Power-on reset
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        model_reset();

        // Game 1: 3 LAND + 2 CLIMB -> 23
        pulse("start1", 0, 0, 0, 1);
        pulse("g1_land1", 1, 0, 0, 0);
        pulse("g1_land2", 1, 0, 0, 0);
        pulse("g1_land3", 1, 0, 0, 0);
        pulse("g1_climb1", 0, 1, 0, 0);
        pulse("g1_climb2", 0, 1, 0, 0);
`ifndef SCORE_COMBO_EN
        check("g1_total", DOUT, 23);
`endif
        pulse("g1_start_ignored", 0, 0, 0, 1);
        pulse("g1_dead", 0, 0, 1, 0);
        pulse("g1_land_in_over", 1, 0, 0, 0);

        // Game 2: score 5 below hi, display alternation in OVER
        pulse("start2", 0, 0, 0, 1);
        repeat (5) pulse("g2_land", 1, 0, 0, 0);
        pulse("g2_dead", 0, 0, 1, 0);
        seen = 0;
        held = 1;
        for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (SHOW_HI === 1'b1) begin
                seen = 1;
                break;
            end
            if (DOUT !== m_score) held = 0;
        end
        check("alt_first_toggle_seen", {31'd0, seen}, 1);
        check("alt_score_held", {31'd0, held}, 1);
        check("alt_dout_hi", DOUT, m_hi);
        n = 0;
        while (SHOW_HI === 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("alt_period", n, TB_ALT * TB_TICK);
        check("alt_dout_back", DOUT, m_score);
        pulse("start_from_over", 0, 0, 0, 1);

        // Game 3: 30 beats hi
        repeat (3) pulse("g3_climb", 0, 1, 0, 0);
        pulse("g3_dead", 0, 0, 1, 0);

        // Game 4: 40, then LAND+CLIMB+DEAD together -> 51, new hi
        pulse("start4", 0, 0, 0, 1);
        repeat (4) pulse("g4_climb", 0, 1, 0, 0);
        pulse("g4_land_climb_dead", 1, 1, 1, 0);
        check("g4_final", DOUT, 51);
        seen = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (SHOW_HI === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("g4_hi_seen", {31'd0, seen}, 1);
        check("g4_hi_value", DOUT, 51);

        // Game 5: equal score does not set HI_NEW
        pulse("start5", 0, 0, 0, 1);
        repeat (5) pulse("g5_climb", 0, 1, 0, 0);
        pulse("g5_land", 1, 0, 0, 0);
        pulse("g5_dead_equal", 0, 0, 1, 0);
        check("g5_hi_new_equal", {31'd0, HI_NEW}, 0);

        // Game 6: saturation at SCORE_MAX
        pulse("start6", 0, 0, 0, 1);
        @(negedge CLK);
        CLIMB = 1;
        model_cycle(0, 1, 0, 0);
        repeat (998) begin
            @(negedge CLK);
            model_cycle(0, 1, 0, 0);
        end
        @(negedge CLK);
        CLIMB = 0;
        exp_q.push_back(m_score);
        @(negedge CLK);
        check("g6_run_9990", DOUT, exp_q.pop_front());
        while (m_score < 9995) pulse("g6_land_fill", 1, 0, 0, 0);
        pulse("g6_climb_sat", 0, 1, 0, 0);
        check("g6_sat_value", DOUT, TB_MAX);
        pulse("g6_land_sat1", 1, 0, 0, 0);
        pulse("g6_land_sat2", 1, 0, 0, 0);
        pulse("g6_dead", 0, 0, 1, 0);

        // Game 7: asynchronous reset mid-PLAY
        pulse("start7", 0, 0, 0, 1);
        pulse("g7_land", 1, 0, 0, 0);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Game 8: high score was cleared by reset
        pulse("start8", 0, 0, 0, 1);
        pulse("g8_climb", 0, 1, 0, 0);
        pulse("g8_dead", 0, 0, 1, 0);
        check("g8_hi_new_after_reset", {31'd0, HI_NEW}, 1);

`ifdef SCORE_COMBO_EN
        // Combo: two LANDs 5 ms apart -> +1, +2; a third 1 s later -> +1
        pulse("start9", 0, 0, 0, 1);
        pulse("g9_land1", 1, 0, 0, 0);
        check("combo_first", DOUT, 1);
        repeat (5 * TB_TICK - 3) @(negedge CLK);
        pulse("g9_land2", 1, 0, 0, 0);
        check("combo_second", DOUT, 3);
        repeat (1000 * TB_TICK) @(negedge CLK);
        pulse("g9_land3", 1, 0, 0, 0);
        check("combo_expired", DOUT, 4);
`endif

        base = exp_q.size();
        check("scoreboard_drained", base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_score_keeper
`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-score stage for Doodle Fall. Accumulates points from gameplay event pulses and tracks the session high score.
- Drives the 32-bit binary DIN of ssdCtrl directly upstream, and selects whether the display shows the current score or the high score.
- Score saturates at the 4-digit display limit.

Parameters:
- SCORE_MAX, 9999: saturation ceiling for score and high score; must be below 2^14.
- LAND_PTS, 1: points per LAND pulse.
- CLIMB_PTS, 10: points per CLIMB pulse.
- TICK_DIV, 100000: CLK cycles per 1 ms tick (100 MHz).
- ALT_MS, 500: display alternation period in GAME_OVER, in ms.
- COMBO_MS, 750: combo window in ms (used only with the optional feature).

Ports:
- CLK  in  1  100 MHz system clock
- RST  in  1  reset; asynchronous assert, active-high
- START  in  1  one-cycle pulse: begin a new game
- LAND  in  1  one-cycle pulse: player landed on a platform
- CLIMB  in  1  one-cycle pulse: player crossed a height band
- DEAD  in  1  one-cycle pulse: player fell off screen
- DOUT  out  32  binary value to display; upper 18 bits are always 0
- SHOW_HI  out  1  1 while DOUT carries the high score
- HI_NEW  out  1  1 once the finished game's score has beaten the high score
- STATE  out  2  00 IDLE, 01 PLAY, 10 OVER

Behaviour:
- Reset (async) clears all registers: score=0, hi=0, DOUT=0, SHOW_HI=1, HI_NEW=0, STATE=IDLE, tick and alternation counters=0.
- FSM:
  - IDLE: DOUT=hi, SHOW_HI=1. START -> PLAY.
  - PLAY: SHOW_HI=0, DOUT=score. DEAD -> OVER. START is ignored.
  - OVER: DOUT alternates score/hi every ALT_MS ms, starting with score (SHOW_HI=0). START -> PLAY.
- On PLAY entry: score<=0, HI_NEW<=0, alternation counter<=0.
- Scoring is active only in PLAY:
  - per cycle, add = LAND*LAND_PTS + CLIMB*CLIMB_PTS;
  - score <= min(score+add, SCORE_MAX);
  - the sum is computed 15 bits wide before clamping.
- DEAD in the same cycle as LAND/CLIMB: that cycle's points are counted, then the FSM enters OVER.
- On the PLAY->OVER transition, compare against the final score including same-cycle points. If final score > hi: hi<=final score and HI_NEW<=1. Equal scores do not set HI_NEW.
- Event pulses in IDLE/OVER are ignored. START and DEAD together in PLAY: DEAD wins.
- Timing:
  - 1 ms tick is a free-running divider: tick is asserted when the counter reaches TICK_DIV-1, then the counter wraps to 0.
  - Alternation counter counts ticks only in OVER. When it reaches ALT_MS-1 on a tick, it toggles SHOW_HI and wraps.
- Latency: DOUT, SHOW_HI, HI_NEW and STATE are registered. DOUT reflects a score change one cycle after the update cycle, i.e. 2 cycles after the event pulse.
- RST mid-game clears the high score too (no retention across reset).

Optional Feature:
- Macro: SCORE_COMBO_EN.
- Defined:
  - LAND within COMBO_MS ms of the previous LAND in the same game scores 2*LAND_PTS; otherwise LAND_PTS.
  - A combo timer (ms ticks) restarts on each LAND and saturates at COMBO_MS.
  - The timer is cleared to "expired" on PLAY entry, so the first LAND of a game is never a combo.
- Undefined: no combo timer is built; LAND always scores LAND_PTS.

Decomposition:
- Package score_pkg holds:
  - state encodings IDLE/PLAY/OVER;
  - score width constant SCORE_W=14;
  - display width DOUT_W=32.
- One sub-module is natural: ms_tick_gen (TICK_DIV divider producing a one-cycle tick). It is reusable elsewhere in the design.
- Sub-module test point: reduce TICK_DIV in simulation, e.g. 10.

Test Plan:
- Reset, then START; 3 LAND + 2 CLIMB pulses spaced 2 cycles apart -> STATE=01, DOUT=23 two cycles after the last pulse.
- In PLAY with score=9995, one CLIMB -> DOUT=9999; further LANDs keep DOUT at 9999.
- Same-cycle LAND+CLIMB+DEAD at score 40, hi=30 -> score 51, STATE=10, hi=51, HI_NEW=1.
- In OVER (TICK_DIV=10, ALT_MS=3), score=5, hi=8:
  - DOUT=5 for 30 cycles, then DOUT=8 with SHOW_HI=1, then back to 5.
  - Then START -> DOUT=0, HI_NEW=0, STATE=01.
- Score equal to hi at DEAD -> HI_NEW stays 0.
- RST asserted asynchronously mid-PLAY between clock edges -> all outputs reach reset values immediately.
- With SCORE_COMBO_EN: two LANDs 5 ms apart -> +1 then +2; a third LAND 1 s later -> +1.
